// File: rtl/carry_gen_check_if.sv
`default_nettype none
// ============================================================================
// Module      : carry_gen_check_if
// Description : Stimulus/response vector channel into the carry-generator
//               response checker. The bench side (master) presents one
//               vector per cycle. The checker (slave) accepts it when
//               vec_ready is high.
// Ports       : vec_valid  - a vector is present
//               vec_ready  - checker accepts a vector this cycle
//               vec_last   - final vector of the run
//               cin, a, b  - stimulus applied to the carry generator
//               c, cout    - carries observed from the carry generator
// Revision    : 1.0 - initial release
// ============================================================================
interface carry_gen_check_if #(
  parameter int WIDTH = 4
);
  logic             vec_valid;
  logic             vec_ready;
  logic             vec_last;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             cout;

  modport master (
    output vec_valid, vec_last, cin, a, b, c, cout,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_last, cin, a, b, c, cout,
    output vec_ready
  );
endinterface
`default_nettype wire

// File: rtl/carry_gen_check.sv
`default_nettype none
// ============================================================================
// Module      : carry_gen_check
// Description : Clocked response checker for the carry lookahead path.
//               Accepts one vector per cycle and recomputes the golden
//               carries from a stage register. Counts passing and failing
//               vectors and captures the first failing vector of a run.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               start           - begins a run (honoured in IDLE / DONE)
//               vec             - vector channel (slave modport)
//               busy, done      - run in progress / run complete
//               pass            - run complete with no failing vectors
//               vec_count       - vectors checked (saturating)
//               err_count       - failing vectors (saturating)
//               first_err_a/b   - operands of first failing vector
//               first_err_cin   - carry-in of first failing vector
//               first_err_mask  - per-bit mismatch, bit WIDTH = cout
// Revision    : 1.0 - initial release
// ============================================================================
module carry_gen_check #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  carry_gen_check_if.slave      vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      vec_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [WIDTH-1:0]      first_err_a,
  output logic [WIDTH-1:0]      first_err_b,
  output logic                  first_err_cin,
  output logic [WIDTH:0]        first_err_mask
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           r_state;

  // Single stage holding the vector accepted on the previous edge.
  logic             r_stg_valid;
  logic [WIDTH-1:0] r_stg_a;
  logic [WIDTH-1:0] r_stg_b;
  logic             r_stg_cin;
  logic [WIDTH-1:0] r_stg_c;
  logic             r_stg_cout;

  logic             w_hs;
  logic             w_clear;
  logic [WIDTH:0]   w_e;
  logic [WIDTH:0]   w_mismatch;

  assign vec.vec_ready = (r_state == S_RUN);
  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign pass          = (r_state == S_DONE) && (err_count == '0);

  assign w_hs    = vec.vec_valid && (r_state == S_RUN);
  assign w_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Golden ripple of generate/propagate over the staged operands.
  // Built inside one block so the chain is evaluated in bit order.
  always_comb begin
    w_e    = '0;
    w_e[0] = r_stg_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_e[i+1] = (r_stg_a[i] & r_stg_b[i]) |
                 ((r_stg_a[i] ^ r_stg_b[i]) & w_e[i]);
    end
  end

  assign w_mismatch = {r_stg_cout, r_stg_c} ^ w_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_stg_valid    <= 1'b0;
      r_stg_a        <= '0;
      r_stg_b        <= '0;
      r_stg_cin      <= 1'b0;
      r_stg_c        <= '0;
      r_stg_cout     <= 1'b0;
      vec_count      <= '0;
      err_count      <= '0;
      first_err_a    <= '0;
      first_err_b    <= '0;
      first_err_cin  <= 1'b0;
      first_err_mask <= '0;
    end else begin
      r_stg_valid <= w_hs;
      if (w_hs) begin
        r_stg_a    <= vec.a;
        r_stg_b    <= vec.b;
        r_stg_cin  <= vec.cin;
        r_stg_c    <= vec.c;
        r_stg_cout <= vec.cout;
      end

      case (r_state)
        S_IDLE, S_DONE: if (start) r_state <= S_RUN;
        S_RUN:          if (w_hs && vec.vec_last) r_state <= S_DRAIN;
        S_DRAIN:        r_state <= S_DONE;
        default:        r_state <= S_IDLE;
      endcase

      // The stage is never valid in IDLE/DONE, so clearing and scoring
      // cannot both be wanted on the same edge.
      if (w_clear) begin
        vec_count      <= '0;
        err_count      <= '0;
        first_err_a    <= '0;
        first_err_b    <= '0;
        first_err_cin  <= 1'b0;
        first_err_mask <= '0;
      end else if (r_stg_valid) begin
        if (vec_count != C_CNT_MAX) vec_count <= vec_count + C_CNT_ONE;
        if (w_mismatch != '0) begin
          if (err_count != C_CNT_MAX) err_count <= err_count + C_CNT_ONE;
          // A zero error count marks the first failure of the run.
          if (err_count == '0) begin
            first_err_a    <= r_stg_a;
            first_err_b    <= r_stg_b;
            first_err_cin  <= r_stg_cin;
            first_err_mask <= w_mismatch;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_carry_gen_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_gen_check
// Description : Directed self-checking bench for carry_gen_check. A main
//               instance (CNT_W = 16) covers reset, clean, faulty, gapped
//               and restarted runs. A second instance (CNT_W = 3) covers
//               counter saturation and a start pulse ignored mid-run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_gen_check;

  logic clk;
  logic rst_n;
  logic start;
  logic sat_start;

  int n_chk;
  int n_pass;

  carry_gen_check_if #(.WIDTH(4)) m_if ();
  carry_gen_check_if #(.WIDTH(4)) s_if ();

  logic        busy, done, pass, fe_cin;
  logic [15:0] vec_count, err_count;
  logic [3:0]  fe_a, fe_b;
  logic [4:0]  fe_mask;

  logic        s_busy, s_done, s_pass, s_fe_cin;
  logic [2:0]  s_vec_count, s_err_count;
  logic [3:0]  s_fe_a, s_fe_b;
  logic [4:0]  s_fe_mask;

  carry_gen_check #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vec            (m_if),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .vec_count      (vec_count),
    .err_count      (err_count),
    .first_err_a    (fe_a),
    .first_err_b    (fe_b),
    .first_err_cin  (fe_cin),
    .first_err_mask (fe_mask)
  );

  carry_gen_check #(.WIDTH(4), .CNT_W(3)) u_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (sat_start),
    .vec            (s_if),
    .busy           (s_busy),
    .done           (s_done),
    .pass           (s_pass),
    .vec_count      (s_vec_count),
    .err_count      (s_err_count),
    .first_err_a    (s_fe_a),
    .first_err_b    (s_fe_b),
    .first_err_cin  (s_fe_cin),
    .first_err_mask (s_fe_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Correct carry response {cout, c}: carry into bit i is bit i of the sum
  // of the low i bits of both operands plus cin.
  function automatic logic [4:0] resp(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [4:0] r;
    int s;
    for (int i = 0; i < 4; i++) begin
      s    = int'(a & 4'((1 << i) - 1)) + int'(b & 4'((1 << i) - 1)) + int'(cin);
      r[i] = s[i];
    end
    s    = int'(a) + int'(b) + int'(cin);
    r[4] = s[4];
    return r;
  endfunction

  // Present one vector on the main channel for one cycle (negedge to negedge).
  task automatic drv(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input logic [4:0] rsp, input logic last);
    m_if.a         = a;
    m_if.b         = b;
    m_if.cin       = cin;
    m_if.c         = rsp[3:0];
    m_if.cout      = rsp[4];
    m_if.vec_last  = last;
    m_if.vec_valid = 1'b1;
    @(negedge clk);
    m_if.vec_valid = 1'b0;
    m_if.vec_last  = 1'b0;
  endtask

  task automatic sat_drv(input logic [4:0] rsp, input logic last);
    s_if.a         = 4'b0000;
    s_if.b         = 4'b0000;
    s_if.cin       = 1'b0;
    s_if.c         = rsp[3:0];
    s_if.cout      = rsp[4];
    s_if.vec_last  = last;
    s_if.vec_valid = 1'b1;
    @(negedge clk);
    s_if.vec_valid = 1'b0;
    s_if.vec_last  = 1'b0;
  endtask

  task automatic gap();
    m_if.vec_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    pulse_start();
    n_chk++; if (m_if.vec_ready !== 1'b1) $display("FAIL start_ready: got %b want 1", m_if.vec_ready); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else n_pass++;
    drv(4'b0111, 4'b0001, 1'b0, 5'b00110, 1'b0);
    drv(4'b0011, 4'b0101, 1'b1, resp(4'b0011, 4'b0101, 1'b1), 1'b0);
    gap();
    n_chk++; if (err_count !== 16'd1) $display("FAIL prereset_err: got %0d want 1", err_count); else n_pass++;
    // Vector on the channel while reset hits mid-cycle, before any edge.
    m_if.vec_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (m_if.vec_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", m_if.vec_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL rst_pass: got %b want 0", pass); else n_pass++;
    n_chk++; if (vec_count !== 16'd0) $display("FAIL rst_vec_count: got %0d want 0", vec_count); else n_pass++;
    n_chk++; if (err_count !== 16'd0) $display("FAIL rst_err_count: got %0d want 0", err_count); else n_pass++;
    n_chk++; if (fe_a !== 4'b0000) $display("FAIL rst_first_err_a: got %b want 0000", fe_a); else n_pass++;
    n_chk++; if (fe_mask !== 5'b00000) $display("FAIL rst_first_err_mask: got %b want 00000", fe_mask); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (m_if.vec_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", m_if.vec_ready); else n_pass++;
    n_chk++; if (vec_count !== 16'd0) $display("FAIL idle_vec_count: got %0d want 0", vec_count); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    m_if.vec_valid = 1'b0;
  endtask

  task automatic test_clean();
    logic [3:0] a, b;
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      a = 4'(i + 1);
      b = 4'((i * 5) & 15);
      drv(a, b, 1'b0, resp(a, b, 1'b0), (i == 14));
    end
    n_chk++; if (done !== 1'b0) $display("FAIL clean_drain_done: got %b want 0", done); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL clean_drain_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1) $display("FAIL clean_done: got %b want 1", done); else n_pass++;
    n_chk++; if (vec_count !== 16'd15) $display("FAIL clean_vec_count: got %0d want 15", vec_count); else n_pass++;
    n_chk++; if (err_count !== 16'd0) $display("FAIL clean_err_count: got %0d want 0", err_count); else n_pass++;
    n_chk++; if (pass !== 1'b1) $display("FAIL clean_pass: got %b want 1", pass); else n_pass++;
  endtask

  task automatic test_fault();
    pulse_start();
    drv(4'b0111, 4'b0001, 1'b0, 5'b00110, 1'b0);
    drv(4'b0011, 4'b0101, 1'b1, resp(4'b0011, 4'b0101, 1'b1), 1'b1);
    @(negedge clk);
    n_chk++; if (err_count !== 16'd1) $display("FAIL fault_err_count: got %0d want 1", err_count); else n_pass++;
    n_chk++; if (vec_count !== 16'd2) $display("FAIL fault_vec_count: got %0d want 2", vec_count); else n_pass++;
    n_chk++; if (fe_a !== 4'b0111) $display("FAIL fault_first_err_a: got %b want 0111", fe_a); else n_pass++;
    n_chk++; if (fe_b !== 4'b0001) $display("FAIL fault_first_err_b: got %b want 0001", fe_b); else n_pass++;
    n_chk++; if (fe_cin !== 1'b0) $display("FAIL fault_first_err_cin: got %b want 0", fe_cin); else n_pass++;
    n_chk++; if (fe_mask !== 5'b01000) $display("FAIL fault_first_err_mask: got %b want 01000", fe_mask); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL fault_pass: got %b want 0", pass); else n_pass++;
  endtask

  task automatic test_gapped();
    pulse_start();
    drv(4'b0001, 4'b0010, 1'b0, resp(4'b0001, 4'b0010, 1'b0), 1'b0);  // v1
    gap();
    n_chk++; if (vec_count !== 16'd1) $display("FAIL gap_count_v1: got %0d want 1", vec_count); else n_pass++;
    drv(4'b1100, 4'b0110, 1'b0, resp(4'b1100, 4'b0110, 1'b0), 1'b0);  // v2
    drv(4'b1111, 4'b1111, 1'b1, resp(4'b1111, 4'b1111, 1'b1), 1'b0);  // v3
    gap();
    n_chk++; if (vec_count !== 16'd3) $display("FAIL gap_count_v3: got %0d want 3", vec_count); else n_pass++;
    // v4: correct is c=1111 cout=0; cout reported wrong.
    drv(4'b0101, 4'b0011, 1'b1, 5'b11111, 1'b0);
    // v5: correct is c=0000 cout=1; c[0] reported wrong.
    drv(4'b1000, 4'b1000, 1'b0, 5'b10001, 1'b0);
    gap();
    drv(4'b0010, 4'b0010, 1'b0, resp(4'b0010, 4'b0010, 1'b0), 1'b1);  // v6
    @(negedge clk);
    n_chk++; if (vec_count !== 16'd6) $display("FAIL gap_vec_count: got %0d want 6", vec_count); else n_pass++;
    n_chk++; if (err_count !== 16'd2) $display("FAIL gap_err_count: got %0d want 2", err_count); else n_pass++;
    n_chk++; if (fe_a !== 4'b0101) $display("FAIL gap_first_err_a: got %b want 0101", fe_a); else n_pass++;
    n_chk++; if (fe_b !== 4'b0011) $display("FAIL gap_first_err_b: got %b want 0011", fe_b); else n_pass++;
    n_chk++; if (fe_cin !== 1'b1) $display("FAIL gap_first_err_cin: got %b want 1", fe_cin); else n_pass++;
    n_chk++; if (fe_mask !== 5'b10000) $display("FAIL gap_first_err_mask: got %b want 10000", fe_mask); else n_pass++;
  endtask

  task automatic test_restart();
    pulse_start();
    n_chk++; if (vec_count !== 16'd0) $display("FAIL restart_clr_vec: got %0d want 0", vec_count); else n_pass++;
    n_chk++; if (err_count !== 16'd0) $display("FAIL restart_clr_err: got %0d want 0", err_count); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL restart_done_fall: got %b want 0", done); else n_pass++;
    n_chk++; if (fe_mask !== 5'b00000) $display("FAIL restart_clr_mask: got %b want 00000", fe_mask); else n_pass++;
    drv(4'b1010, 4'b0101, 1'b1, resp(4'b1010, 4'b0101, 1'b1), 1'b0);
    drv(4'b0110, 4'b0011, 1'b0, resp(4'b0110, 4'b0011, 1'b0), 1'b0);
    drv(4'b1001, 4'b1001, 1'b1, resp(4'b1001, 4'b1001, 1'b1), 1'b1);
    @(negedge clk);
    n_chk++; if (vec_count !== 16'd3) $display("FAIL restart_vec_count: got %0d want 3", vec_count); else n_pass++;
    n_chk++; if (err_count !== 16'd0) $display("FAIL restart_err_count: got %0d want 0", err_count); else n_pass++;
    n_chk++; if (pass !== 1'b1) $display("FAIL restart_pass: got %b want 1", pass); else n_pass++;
  endtask

  task automatic test_saturation();
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    // 0+0 with cin=0 has all carries 0; c[0] reported as 1 fails each time.
    for (int i = 0; i < 10; i++) begin
      sat_start = (i == 4);
      sat_drv(5'b00001, (i == 9));
      sat_start = 1'b0;
      if (i == 5) begin
        n_chk++; if (s_vec_count !== 3'd5) $display("FAIL sat_no_restart_count: got %0d want 5", s_vec_count); else n_pass++;
        n_chk++; if (s_busy !== 1'b1) $display("FAIL sat_busy: got %b want 1", s_busy); else n_pass++;
      end
    end
    @(negedge clk);
    n_chk++; if (s_vec_count !== 3'd7) $display("FAIL sat_vec_count: got %0d want 7", s_vec_count); else n_pass++;
    n_chk++; if (s_err_count !== 3'd7) $display("FAIL sat_err_count: got %0d want 7", s_err_count); else n_pass++;
    n_chk++; if (s_done !== 1'b1) $display("FAIL sat_done: got %b want 1", s_done); else n_pass++;
    n_chk++; if (s_pass !== 1'b0) $display("FAIL sat_pass: got %b want 0", s_pass); else n_pass++;
    n_chk++; if (s_fe_mask !== 5'b00001) $display("FAIL sat_first_err_mask: got %b want 00001", s_fe_mask); else n_pass++;
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    sat_start      = 1'b0;
    m_if.vec_valid = 1'b0;
    m_if.vec_last  = 1'b0;
    m_if.cin       = 1'b0;
    m_if.a         = '0;
    m_if.b         = '0;
    m_if.c         = '0;
    m_if.cout      = 1'b0;
    s_if.vec_valid = 1'b0;
    s_if.vec_last  = 1'b0;
    s_if.cin       = 1'b0;
    s_if.a         = '0;
    s_if.b         = '0;
    s_if.c         = '0;
    s_if.cout      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_clean();
    test_fault();
    test_gapped();
    test_restart();
    test_saturation();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
